// File: rtl/riscv_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : riscv_mc_ctrl
// Description : Multicycle RISC-V control sequencer. It drives the memory
//               handshake, register write enables and datapath mux selects,
//               and keeps a 16-bit retired-instruction counter.
//               Optional macro RISCV_MC_CTRL_ILLEGAL_TRAP_EN: an unknown
//               opcode parks the FSM in HALT and sets the sticky illegal
//               flag. Without the macro, an unknown opcode retires as a NOP.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_mc_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        pc_we,
  output logic        ir_we,
  output logic        oldpc_we,
  output logic        reg_we,
  output logic        adr_src,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  result_src,
  output logic [2:0]  alu_ctrl,
  output logic [3:0]  state,
  output logic [15:0] instret,
  output logic        illegal
);

  typedef enum logic [3:0] {
    S_RST    = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC_R = 4'd7,
    S_EXEC_I = 4'd8,
    S_ALUWB  = 4'd9,
    S_BRANCH = 4'd10,
    S_JAL    = 4'd11,
    S_LUI    = 4'd12,
    S_HALT   = 4'd13
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  state_t      state_q, state_d;
  logic [15:0] instret_q, instret_d;
  logic        retire;
  logic [2:0]  exec_alu;
  logic        branch_taken;

  // ALU operation for the execute states, decoded from funct3 (sub only for R-type)
  always_comb begin
    exec_alu = ALU_ADD;
    case (funct3)
      3'b000:  exec_alu = (state_q == S_EXEC_R && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  exec_alu = ALU_SLL;
      3'b010:  exec_alu = ALU_SLT;
      3'b011:  exec_alu = ALU_ADD;
      3'b100:  exec_alu = ALU_XOR;
      3'b101:  exec_alu = ALU_SRL;
      3'b110:  exec_alu = ALU_OR;
      3'b111:  exec_alu = ALU_AND;
      default: exec_alu = ALU_ADD;
    endcase
  end

  // Branch condition: beq on zero, bne on not-zero, other funct3 never taken
  always_comb begin
    branch_taken = 1'b0;
    if (funct3 == 3'b000)      branch_taken = zero;
    else if (funct3 == 3'b001) branch_taken = ~zero;
  end

`ifdef RISCV_MC_CTRL_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;
`endif

  // Next-state, datapath controls and retirement pulse
  always_comb begin
    state_d    = state_q;
    retire     = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    pc_we      = 1'b0;
    ir_we      = 1'b0;
    oldpc_we   = 1'b0;
    reg_we     = 1'b0;
    adr_src    = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    alu_ctrl   = ALU_ADD;
`ifdef RISCV_MC_CTRL_ILLEGAL_TRAP_EN
    illegal_d  = illegal_q;
`endif
    case (state_q)
      S_RST: state_d = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we      = 1'b1;
          oldpc_we   = 1'b1;
          pc_we      = 1'b1;
          alu_src_b  = 2'b10;
          result_src = 2'b10;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        // Precompute the branch/jump target into ALUOut
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXEC_R;
          OP_I:              state_d = S_EXEC_I;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_LUI:            state_d = S_LUI;
          default: begin
`ifdef RISCV_MC_CTRL_ILLEGAL_TRAP_EN
            state_d   = S_HALT;
            illegal_d = 1'b1;
`else
            state_d   = S_FETCH;
            retire    = 1'b1;
`endif
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (opcode == OP_LOAD) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_we     = 1'b1;
        state_d    = S_FETCH;
        retire     = 1'b1;
      end
      S_MEMWR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_EXEC_R: begin
        alu_src_a = 2'b10;
        alu_ctrl  = exec_alu;
        state_d   = S_ALUWB;
      end
      S_EXEC_I: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_ctrl  = exec_alu;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_we  = 1'b1;
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 2'b10;
        alu_ctrl  = ALU_SUB;
        pc_we     = branch_taken;
        state_d   = S_FETCH;
        retire    = 1'b1;
      end
      S_JAL: begin
        // rd takes oldPC+4 from the ALU; PC takes the target held in ALUOut
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_we     = 1'b1;
        reg_we    = 1'b1;
        state_d   = S_FETCH;
        retire    = 1'b1;
      end
      S_LUI: begin
        result_src = 2'b11;
        reg_we     = 1'b1;
        state_d    = S_FETCH;
        retire     = 1'b1;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_RST;
    endcase
    instret_d = retire ? (instret_q + 16'd1) : instret_q;
  end

  // State and counter registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_RST;
      instret_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

`ifdef RISCV_MC_CTRL_ILLEGAL_TRAP_EN
  // Sticky illegal-opcode flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (!rst) illegal_q <= 1'b0;
    else      illegal_q <= illegal_d;
  end
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  assign state   = state_q;
  assign instret = instret_q;

endmodule
`default_nettype wire
